// File: rtl/pipelined_cla_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_cla_adder
// Brief    : Pipelined carry-lookahead adder/subtractor. One CHUNK-bit slice
//            is resolved per stage, and the inter-slice carry is registered.
//            Valid/ready flow control is provided on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_cla_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int STAGES = WIDTH / CHUNK;

    // Slice adder with generate/propagate lookahead; returns {carry_out, sum}.
    function automatic logic [CHUNK:0] f_slice_add(
        input logic [CHUNK-1:0] x,
        input logic [CHUNK-1:0] y,
        input logic             ci
    );
        logic [CHUNK:0]   c;
        logic [CHUNK-1:0] g;
        logic [CHUNK-1:0] p;
        logic [CHUNK-1:0] s;
        g    = x & y;
        p    = x | y;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < CHUNK; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        s = x ^ y ^ c[CHUNK-1:0];
        return {c[CHUNK], s};
    endfunction

    logic              w_adv;
    logic [WIDTH-1:0]  w_b_eff;
    logic              w_c_eff;
    logic [CHUNK:0]    w_slice  [STAGES];
    logic [WIDTH-1:0]  w_a_nx   [STAGES];
    logic [WIDTH-1:0]  w_b_nx   [STAGES];
    logic [WIDTH-1:0]  w_sum_nx [STAGES];
    logic [STAGES-1:0] w_c_nx;
    logic              w_ovf;
    logic              w_zero;

    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] r_c;
    logic [WIDTH-1:0]  r_a   [STAGES];
    logic [WIDTH-1:0]  r_b   [STAGES];
    logic [WIDTH-1:0]  r_sum [STAGES];
    logic              r_ovf;
    logic              r_zero;

    assign w_adv    = !r_valid[STAGES-1] || out_ready;
    assign in_ready = w_adv && !rst;
    assign w_b_eff  = sub ? ~b : b;
    assign w_c_eff  = sub | cin;

    // Stage k consumes slice k of the operands it carries; lower sum slices
    // ride along untouched and upper operand slices wait for later stages.
    always_comb begin : p_stage_next
        w_slice[0]  = f_slice_add(a[CHUNK-1:0], w_b_eff[CHUNK-1:0], w_c_eff);
        w_a_nx[0]   = a;
        w_b_nx[0]   = w_b_eff;
        w_sum_nx[0] = '0;
        w_sum_nx[0][CHUNK-1:0] = w_slice[0][CHUNK-1:0];
        w_c_nx      = '0;
        w_c_nx[0]   = w_slice[0][CHUNK];
        for (int k = 1; k < STAGES; k++) begin
            w_slice[k]  = f_slice_add(r_a[k-1][k*CHUNK +: CHUNK],
                                      r_b[k-1][k*CHUNK +: CHUNK],
                                      r_c[k-1]);
            w_a_nx[k]   = r_a[k-1];
            w_b_nx[k]   = r_b[k-1];
            w_sum_nx[k] = r_sum[k-1];
            w_sum_nx[k][k*CHUNK +: CHUNK] = w_slice[k][CHUNK-1:0];
            w_c_nx[k]   = w_slice[k][CHUNK];
        end
        w_ovf  = (w_a_nx[STAGES-1][WIDTH-1] == w_b_nx[STAGES-1][WIDTH-1]) &&
                 (w_sum_nx[STAGES-1][WIDTH-1] != w_a_nx[STAGES-1][WIDTH-1]);
        w_zero = ~|w_sum_nx[STAGES-1];
    end

    // Whole pipeline advances together; a stalled output freezes every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_c     <= '0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_sum[k] <= '0;
            end
        end else if (w_adv) begin
            r_valid[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                r_valid[k] <= r_valid[k-1];
            end
            r_c    <= w_c_nx;
            r_ovf  <= w_ovf;
            r_zero <= w_zero;
            for (int k = 0; k < STAGES; k++) begin
                r_a[k]   <= w_a_nx[k];
                r_b[k]   <= w_b_nx[k];
                r_sum[k] <= w_sum_nx[k];
            end
        end
    end

    assign out_valid = r_valid[STAGES-1];
    assign sum       = r_sum[STAGES-1];
    assign cout      = r_c[STAGES-1];
    assign ovf       = r_ovf;
    assign zero      = r_zero;

endmodule
`default_nettype wire

// File: doc/pipelined_cla_adder.md
# pipelined_cla_adder

Parametrised, pipelined carry-lookahead adder/subtractor: the next generation of the team's fixed 16-bit combinational adder. The operand is split into CHUNK-bit slices. Each slice is added with full generate/propagate lookahead in its own pipeline stage, and the inter-slice carry is registered between stages. The block sits on datapath streams behind a valid/ready handshake and sustains one operation per cycle with backpressure. It also reports carry-out, signed overflow and zero.

## Interface
- WIDTH, 32: operand/result width. Must be a multiple of CHUNK and at least CHUNK.
- CHUNK, 8: bits per lookahead slice. STAGES = WIDTH/CHUNK is both the pipeline depth and the latency.
- clk  in  1  the single clock. All state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat is valid.
- in_ready  out  1  block accepts the beat this cycle.
- a, b  in  WIDTH each  operands.
- cin  in  1  carry-in. Ignored when sub=1.
- sub  in  1  0: a+b+cin. 1: a-b, computed as a + ~b + 1.
- out_valid  out  1  result beat is valid.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result modulo 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1. For subtraction, 1 means no borrow (a >= b unsigned).
- ovf  out  1  two's-complement signed overflow.
- zero  out  1  sum == 0.

## Operation
- Pipeline enable: adv = !out_valid || out_ready. All stage registers, valid bits included, load only when adv=1. When adv=0 every register holds.
- in_ready = adv && !rst. A beat transfers when in_valid && in_ready.
- Stage 0 registers the operands. Mode is applied first: b_eff = sub ? ~b : b and c_eff = sub ? 1 : cin.
- Stage k, for k in 0..STAGES-1:
  - Computes slice k: g = a_k & b_k, p = a_k | b_k, c[i+1] = g[i] | p[i]&c[i], s = a_k ^ b_k ^ c.
  - Carry-in is the registered carry from stage k-1, or c_eff for k=0.
  - Already-computed lower sum slices pass forward unchanged.
  - Unconsumed upper operand slices pass forward unchanged.
- Final stage outputs:
  - sum is the concatenated slices.
  - cout is the final slice carry.
  - ovf = (a_msb == b_eff_msb) && (sum_msb != a_msb), using the operand MSBs carried forward through the pipeline.
  - zero = ~|sum.
- Each stage has a valid bit. Bubbles (in_valid=0 while adv=1) propagate as valid=0 and do not corrupt neighbouring beats.
- Results emerge in issue order. There is no reordering and no dropping.

## Timing
- Latency: a beat accepted at rising edge N appears with out_valid=1 after edge N+STAGES-1 when there are no stalls. Each stall cycle adds one cycle.
- Throughput: one beat per cycle while out_ready=1.
- Backpressure: with out_valid=1 and out_ready=0:
  - sum, cout, ovf and zero hold stable.
  - in_ready=0 in the same cycle (combinational from out_ready).
- Reset:
  - All valid bits clear. out_valid=0, sum=0, cout=0, ovf=0, zero=0.
  - in_ready=0 while rst=1 and returns to 1 the cycle after rst deasserts.
- Reset mid-operation: every in-flight beat is discarded and none is emitted afterwards.
- Simultaneous output pop and input push under a full pipeline: both transfer in the same cycle, with no bubble inserted.
- Corner case STAGES=1 (CHUNK=WIDTH): single registered stage, latency 1, same handshake.

## Test plan
- WIDTH=32, CHUNK=8, out_ready=1, sub=0, cin=0, a=0xFFFF_FFFF, b=0x0000_0001 -> 4 cycles later sum=0, cout=1, zero=1, ovf=0.
- Signed overflow:
  - a=0x7FFF_FFFF, b=1, sub=0 -> sum=0x8000_0000, ovf=1, cout=0.
  - a=0x8000_0000, b=1, sub=1 -> sum=0x7FFF_FFFF, ovf=1, cout=1.
- Back-to-back stream of 100 random beats (mixed sub/cin), out_ready toggled pseudo-randomly -> every result matches a reference model in order, with no loss or duplication. sum holds while out_ready=0.
- Carry across every slice boundary: a=0x00FF_FFFF + b=1 -> sum=0x0100_0000. Repeat with a bubble (in_valid=0) inserted between two such beats -> both results correct.
- Assert rst for one cycle with 3 beats in flight -> out_valid=0 next cycle, no stale beat emitted, and the next accepted beat has correct latency 4.
- Parameter sweep: WIDTH=16/CHUNK=16 (latency 1) and WIDTH=64/CHUNK=4 (latency 16) -> exhaustive corner operands (0, 1, max, min-signed) correct.
